// File: rtl/chan_sched_pkg.sv
// Shared types and default sizing for the round-robin channel scheduler.
package chan_sched_pkg;

    localparam int unsigned DEF_PORTNUM = 16;
    localparam int unsigned DEF_TIMEOUT = 64;
    localparam int unsigned DEF_CNTW    = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } sched_state_t;

endpackage

// File: rtl/chan_rr_sched_if.sv
// Request/grant/beat bundle between requesters and the channel scheduler.
interface chan_rr_sched_if
    import chan_sched_pkg::*;
#(
    parameter int unsigned PORTNUM = DEF_PORTNUM,
    parameter int unsigned CNTW    = DEF_CNTW
);
    localparam int unsigned IW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;

    logic [PORTNUM-1:0] i_chann_req;
    logic [PORTNUM-1:0] i_port_en;
    logic               i_beat_vld;
    logic               i_beat_last;
    logic [PORTNUM-1:0] o_grant;
    logic [IW-1:0]      o_grant_idx;
    logic               o_grant_vld;
    logic [CNTW-1:0]    o_beat_cnt;
    logic               o_timeout;
    logic               o_ready;

    modport master (
        output i_chann_req, i_port_en, i_beat_vld, i_beat_last,
        input  o_grant, o_grant_idx, o_grant_vld, o_beat_cnt, o_timeout, o_ready
    );

    modport slave (
        input  i_chann_req, i_port_en, i_beat_vld, i_beat_last,
        output o_grant, o_grant_idx, o_grant_vld, o_beat_cnt, o_timeout, o_ready
    );

endinterface

// File: rtl/chan_rr_sched_rr_pick.sv
// Combinational round-robin picker: first eligible port above i_last, wrapping.
module rr_pick #(
    parameter int unsigned PORTNUM = 16,
    localparam int unsigned IW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1
) (
    input  logic [PORTNUM-1:0] i_elig,
    input  logic [IW-1:0]      i_last,
    output logic [PORTNUM-1:0] o_onehot,
    output logic [IW-1:0]      o_idx,
    output logic               o_vld
);

    logic          w_hi_found;
    logic [IW-1:0] w_hi_idx;
    logic          w_lo_found;
    logic [IW-1:0] w_lo_idx;

    // Lowest eligible port above i_last, and lowest eligible port overall (the wrap case).
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
        for (int unsigned i = 0; i < PORTNUM; i++) begin
            if (i_elig[i] && !w_hi_found && (i > 32'(i_last))) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IW'(i);
            end
            if (i_elig[i] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IW'(i);
            end
        end
    end

    // Prefer the upward match; otherwise wrap to the lowest eligible port.
    always_comb begin
        o_vld    = w_lo_found;
        o_idx    = w_hi_found ? w_hi_idx : w_lo_idx;
        o_onehot = '0;
        if (w_lo_found) begin
            o_onehot[o_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/chan_rr_sched.sv
// Round-robin channel scheduler: grants one port per packet, releases on last beat or idle timeout.
module chan_rr_sched
    import chan_sched_pkg::*;
#(
    parameter int unsigned PORTNUM = DEF_PORTNUM,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned CNTW    = DEF_CNTW
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    chan_rr_sched_if.slave bus
);

    localparam int unsigned    IW       = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
    localparam int unsigned    TW       = $clog2(TIMEOUT) + 1;
    localparam logic [IW-1:0]  LAST_RST = IW'(PORTNUM - 1);
    localparam logic [TW-1:0]  IDLE_MAX = TW'(TIMEOUT - 1);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [PORTNUM-1:0] r_grant;
    logic [IW-1:0]      r_grant_idx;
    logic [IW-1:0]      r_last;
    logic [CNTW-1:0]    r_beat_cnt;
    logic [TW-1:0]      r_idle;
    logic               r_timeout;

    logic [PORTNUM-1:0] w_elig;
    logic [PORTNUM-1:0] w_pick_onehot;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_vld;
    logic               w_end_last;
    logic               w_end_tmo;

    assign w_elig     = bus.i_chann_req & bus.i_port_en;
    // A beat on the threshold cycle suppresses the timeout.
    assign w_end_last = bus.i_beat_vld & bus.i_beat_last;
    assign w_end_tmo  = !bus.i_beat_vld && (r_idle == IDLE_MAX);

    rr_pick #(.PORTNUM(PORTNUM)) u_rr_pick (
        .i_elig   (w_elig),
        .i_last   (r_last),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_vld    (w_pick_vld)
    );

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: IDLE -> GRANT on any eligible request, GRANT -> RELEASE on last beat or timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_pick_vld) w_state_nxt = ST_GRANT;
            ST_GRANT:   if (w_end_last || w_end_tmo) w_state_nxt = ST_RELEASE;
            ST_RELEASE: w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Grant, counters and timeout pulse; request changes during GRANT are not sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_last      <= LAST_RST;
            r_beat_cnt  <= '0;
            r_idle      <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_grant     <= w_pick_onehot;
                        r_grant_idx <= w_pick_idx;
                        r_last      <= w_pick_idx;
                        r_beat_cnt  <= '0;
                        r_idle      <= '0;
                    end
                end
                ST_GRANT: begin
                    if (bus.i_beat_vld) begin
                        r_idle <= '0;
                        if (r_beat_cnt != CNT_MAX) begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end else if (!w_end_tmo) begin
                        r_idle <= r_idle + 1'b1;
                    end
                    if (w_end_last || w_end_tmo) begin
                        r_grant     <= '0;
                        r_grant_idx <= '0;
                    end
                    r_timeout <= w_end_tmo;
                end
                default: ;
            endcase
        end
    end

    assign bus.o_grant     = r_grant;
    assign bus.o_grant_idx = r_grant_idx;
    assign bus.o_grant_vld = |r_grant;
    assign bus.o_beat_cnt  = r_beat_cnt;
    assign bus.o_timeout   = r_timeout;
    assign bus.o_ready     = (r_state == ST_IDLE);

endmodule

// File: tb/tb_chan_rr_sched.sv
// Scenario bench for chan_rr_sched with a scoreboard of expected grant indices.
module tb_chan_rr_sched;

    localparam int NP  = 16;
    localparam int TMO = 64;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    int   m_last = NP - 1;

    always #5 clk = ~clk;

    chan_rr_sched_if #(.PORTNUM(NP), .CNTW(CW)) bus ();

    chan_rr_sched #(.PORTNUM(NP), .TIMEOUT(TMO), .CNTW(CW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Reference round-robin: first eligible port at (last+k) mod NP, k = 1..NP.
    function automatic int model_pick(input logic [NP-1:0] elig, input int last);
        for (int k = 1; k <= NP; k++) begin
            if (elig[(last + k) % NP]) return (last + k) % NP;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output int e);
        if (exp_q.size() == 0) e = -1;
        else e = exp_q.pop_front();
    endtask

    task automatic wait_grant(output bit ok);
        int n = 0;
        while (!bus.o_grant_vld && n < 40) begin
            tick();
            n++;
        end
        ok = bus.o_grant_vld;
    endtask

    task automatic send_beats(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            bus.i_beat_vld  = 1'b1;
            bus.i_beat_last = with_last && (i == n - 1);
            tick();
        end
        bus.i_beat_vld  = 1'b0;
        bus.i_beat_last = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        bus.i_chann_req = '0;
        bus.i_beat_vld  = 1'b0;
        bus.i_beat_last = 1'b0;
        while (!(bus.o_ready && !bus.o_grant_vld) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (!(bus.o_ready === 1'b1 && bus.o_grant_vld === 1'b0)) begin
            errors++;
            $display("FAIL %s_drain: ready=%0b vld=%0b expected ready=1 vld=0", name, bus.o_ready, bus.o_grant_vld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_chann_req = '0;
        bus.i_port_en   = '0;
        bus.i_beat_vld  = 1'b0;
        bus.i_beat_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.o_grant, bus.o_grant_idx, bus.o_grant_vld, bus.o_beat_cnt, bus.o_timeout, bus.o_ready}
            !== {16'h0, 4'h0, 1'b0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values: grant=%h idx=%0d vld=%0b cnt=%0d tmo=%0b rdy=%0b expected 0,0,0,0,0,1",
                     bus.o_grant, bus.o_grant_idx, bus.o_grant_vld, bus.o_beat_cnt, bus.o_timeout, bus.o_ready);
        end
        rst_n = 1'b1;
        m_last = NP - 1;
        tick();
        // Beats with no grant must not touch the counter or the FSM.
        bus.i_beat_vld  = 1'b1;
        bus.i_beat_last = 1'b1;
        repeat (2) tick();
        bus.i_beat_vld  = 1'b0;
        bus.i_beat_last = 1'b0;
        checks++;
        if (bus.o_beat_cnt !== 8'd0 || bus.o_ready !== 1'b1 || bus.o_grant_vld !== 1'b0) begin
            errors++;
            $display("FAIL beat_outside_grant: cnt=%0d rdy=%0b vld=%0b expected 0,1,0", bus.o_beat_cnt, bus.o_ready, bus.o_grant_vld);
        end
    endtask

    task automatic test_basic();
        int e;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'h0005;
        exp_q.push_back(model_pick(16'h0005, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e || bus.o_grant !== (NP'(1) << e) || bus.o_grant_vld !== 1'b1 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_first_grant: grant=%h idx=%0d vld=%0b rdy=%0b expected idx=%0d vld=1 rdy=0",
                     bus.o_grant, bus.o_grant_idx, bus.o_grant_vld, bus.o_ready, e);
        end
        m_last = e;
        send_beats(3, 1'b1);
        checks++;
        if (bus.o_grant !== 16'h0 || bus.o_grant_vld !== 1'b0 || bus.o_beat_cnt !== 8'd3 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_release: grant=%h vld=%0b cnt=%0d rdy=%0b expected 0,0,3,0",
                     bus.o_grant, bus.o_grant_vld, bus.o_beat_cnt, bus.o_ready);
        end
        exp_q.push_back(model_pick(16'h0005, m_last));
        tick();
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_grant_vld !== 1'b0 || bus.o_beat_cnt !== 8'd3) begin
            errors++;
            $display("FAIL basic_idle_gap: rdy=%0b vld=%0b cnt=%0d expected 1,0,3", bus.o_ready, bus.o_grant_vld, bus.o_beat_cnt);
        end
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e || bus.o_grant !== (NP'(1) << e) || bus.o_beat_cnt !== 8'd0) begin
            errors++;
            $display("FAIL basic_second_grant: grant=%h idx=%0d cnt=%0d expected idx=%0d cnt=0",
                     bus.o_grant, bus.o_grant_idx, bus.o_beat_cnt, e);
        end
        m_last = e;
        bus.i_chann_req = '0;
        send_beats(1, 1'b1);
        drain("basic");
    endtask

    task automatic test_rotation();
        int  e;
        int  l;
        int  gap;
        bit  ok;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_last = NP - 1;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'hFFFF;
        l = m_last;
        for (int g = 0; g < 17; g++) begin
            e = model_pick(16'hFFFF, l);
            exp_q.push_back(e);
            l = e;
        end
        wait_grant(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rot_start: vld=%0b expected 1", bus.o_grant_vld);
        end
        for (int g = 0; g < 17; g++) begin
            pop_exp(e);
            checks++;
            if (int'(bus.o_grant_idx) !== e || bus.o_grant !== (NP'(1) << e)) begin
                errors++;
                $display("FAIL rot_idx_%0d: grant=%h idx=%0d expected idx=%0d", g, bus.o_grant, bus.o_grant_idx, e);
            end
            m_last = e;
            if (g == 16) bus.i_chann_req = '0;
            send_beats(1, 1'b1);
            if (g < 16) begin
                gap = 0;
                while (!bus.o_grant_vld && gap < 10) begin
                    gap++;
                    tick();
                end
                checks++;
                if (gap !== 2) begin
                    errors++;
                    $display("FAIL rot_gap_%0d: gap=%0d expected 2", g, gap);
                end
            end
        end
        drain("rotation");
    endtask

    task automatic test_timeout();
        int e;
        int n;
        bit bad;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'h0008;
        exp_q.push_back(model_pick(16'h0008, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e || bus.o_grant_vld !== 1'b1) begin
            errors++;
            $display("FAIL tmo_grant: idx=%0d vld=%0b expected idx=%0d vld=1", bus.o_grant_idx, bus.o_grant_vld, e);
        end
        m_last = e;
        bus.i_chann_req = '0;
        n = 0;
        while (!bus.o_timeout && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TMO) begin
            errors++;
            $display("FAIL tmo_delay: cycles=%0d expected %0d", n, TMO);
        end
        checks++;
        if (bus.o_grant !== 16'h0 || bus.o_grant_vld !== 1'b0 || bus.o_ready !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drop: grant=%h vld=%0b rdy=%0b expected 0,0,0", bus.o_grant, bus.o_grant_vld, bus.o_ready);
        end
        tick();
        checks++;
        if (bus.o_timeout !== 1'b0 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL tmo_pulse_width: tmo=%0b rdy=%0b expected 0,1", bus.o_timeout, bus.o_ready);
        end
        // Threshold boundary: a beat exactly on the last tolerated idle cycle wins.
        bus.i_chann_req = 16'h0008;
        exp_q.push_back(model_pick(16'h0008, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e) begin
            errors++;
            $display("FAIL tmo_regrant: idx=%0d expected %0d", bus.o_grant_idx, e);
        end
        m_last = e;
        bus.i_chann_req = '0;
        bad = 1'b0;
        repeat (TMO - 1) begin
            tick();
            if (bus.o_timeout !== 1'b0 || bus.o_grant_vld !== 1'b1) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL tmo_early: premature release or timeout, vld=%0b tmo=%0b expected vld=1 tmo=0", bus.o_grant_vld, bus.o_timeout);
        end
        send_beats(1, 1'b0);
        checks++;
        if (bus.o_timeout !== 1'b0 || bus.o_grant_vld !== 1'b1 || bus.o_beat_cnt !== 8'd1) begin
            errors++;
            $display("FAIL tmo_beat_wins: tmo=%0b vld=%0b cnt=%0d expected 0,1,1", bus.o_timeout, bus.o_grant_vld, bus.o_beat_cnt);
        end
        n = 0;
        while (!bus.o_timeout && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (n !== TMO || bus.o_beat_cnt !== 8'd1) begin
            errors++;
            $display("FAIL tmo_after_beat: cycles=%0d cnt=%0d expected %0d,1", n, bus.o_beat_cnt, TMO);
        end
        drain("timeout");
    endtask

    task automatic test_mask();
        int e;
        int l;
        bit ok;
        bus.i_port_en   = 16'h00E0;
        bus.i_chann_req = 16'h00F0;
        l = m_last;
        for (int g = 0; g < 6; g++) begin
            e = model_pick(16'h00F0 & 16'h00E0, l);
            exp_q.push_back(e);
            l = e;
        end
        for (int g = 0; g < 6; g++) begin
            wait_grant(ok);
            pop_exp(e);
            checks++;
            if (!ok || int'(bus.o_grant_idx) !== e || bus.o_grant !== (NP'(1) << e)) begin
                errors++;
                $display("FAIL mask_idx_%0d: grant=%h idx=%0d expected idx=%0d", g, bus.o_grant, bus.o_grant_idx, e);
            end
            m_last = e;
            if (g == 5) bus.i_chann_req = '0;
            send_beats(1, 1'b1);
        end
        drain("mask");
        bus.i_port_en = 16'hFFFF;
    endtask

    task automatic test_withdraw();
        int e;
        bit bad;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'h0004;
        exp_q.push_back(model_pick(16'h0004, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e || bus.o_grant !== (NP'(1) << e)) begin
            errors++;
            $display("FAIL wd_grant: grant=%h idx=%0d expected idx=%0d", bus.o_grant, bus.o_grant_idx, e);
        end
        m_last = e;
        send_beats(1, 1'b0);
        bus.i_chann_req = '0;
        bad = 1'b0;
        repeat (3) begin
            tick();
            if (bus.o_grant !== 16'h0004 || bus.o_grant_vld !== 1'b1) bad = 1'b1;
        end
        send_beats(1, 1'b0);
        checks++;
        if (bad || bus.o_grant !== 16'h0004 || bus.o_beat_cnt !== 8'd2) begin
            errors++;
            $display("FAIL wd_hold: grant=%h cnt=%0d dropped=%0b expected grant=0004 cnt=2 dropped=0", bus.o_grant, bus.o_beat_cnt, bad);
        end
        send_beats(1, 1'b1);
        checks++;
        if (bus.o_grant !== 16'h0 || bus.o_beat_cnt !== 8'd3) begin
            errors++;
            $display("FAIL wd_release: grant=%h cnt=%0d expected 0000,3", bus.o_grant, bus.o_beat_cnt);
        end
        drain("withdraw");
    endtask

    task automatic test_reset_mid();
        int e;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'h0300;
        exp_q.push_back(model_pick(16'h0300, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e) begin
            errors++;
            $display("FAIL rstmid_grant: idx=%0d expected %0d", bus.o_grant_idx, e);
        end
        m_last = e;
        send_beats(2, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.o_grant, bus.o_grant_idx, bus.o_grant_vld, bus.o_beat_cnt, bus.o_timeout, bus.o_ready}
            !== {16'h0, 4'h0, 1'b0, 8'h0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_async: grant=%h idx=%0d vld=%0b cnt=%0d tmo=%0b rdy=%0b expected 0,0,0,0,0,1",
                     bus.o_grant, bus.o_grant_idx, bus.o_grant_vld, bus.o_beat_cnt, bus.o_timeout, bus.o_ready);
        end
        tick();
        checks++;
        if (bus.o_grant_vld !== 1'b0 || bus.o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_held: vld=%0b tmo=%0b expected 0,0", bus.o_grant_vld, bus.o_timeout);
        end
        rst_n = 1'b1;
        m_last = NP - 1;
        exp_q.push_back(model_pick(16'h0300, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (bus.o_grant_vld !== 1'b1 || int'(bus.o_grant_idx) !== e) begin
            errors++;
            $display("FAIL rstmid_resume: vld=%0b idx=%0d expected vld=1 idx=%0d", bus.o_grant_vld, bus.o_grant_idx, e);
        end
        m_last = e;
        bus.i_chann_req = '0;
        send_beats(1, 1'b1);
        drain("reset_mid");
    endtask

    task automatic test_beat_sat();
        int e;
        bus.i_port_en   = 16'hFFFF;
        bus.i_chann_req = 16'h0001;
        exp_q.push_back(model_pick(16'h0001, m_last));
        tick();
        pop_exp(e);
        checks++;
        if (int'(bus.o_grant_idx) !== e) begin
            errors++;
            $display("FAIL sat_grant: idx=%0d expected %0d", bus.o_grant_idx, e);
        end
        m_last = e;
        bus.i_chann_req = '0;
        send_beats(255, 1'b0);
        checks++;
        if (bus.o_beat_cnt !== 8'd255) begin
            errors++;
            $display("FAIL sat_reach: cnt=%0d expected 255", bus.o_beat_cnt);
        end
        send_beats(3, 1'b0);
        checks++;
        if (bus.o_beat_cnt !== 8'd255 || bus.o_grant_vld !== 1'b1) begin
            errors++;
            $display("FAIL sat_nowrap: cnt=%0d vld=%0b expected 255,1", bus.o_beat_cnt, bus.o_grant_vld);
        end
        send_beats(1, 1'b1);
        tick();
        checks++;
        if (bus.o_beat_cnt !== 8'd255 || bus.o_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d rdy=%0b expected 255,1", bus.o_beat_cnt, bus.o_ready);
        end
        drain("beat_sat");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rotation();
        test_timeout();
        test_mask();
        test_withdraw();
        test_reset_mid();
        test_beat_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/chan_rr_sched.md
CHAN_RR_SCHED -- requirements
Module: chan_rr_sched

Interface
REQ-001 Parameter PORTNUM, default 16, number of requesting ports.
REQ-002 Parameter TIMEOUT, default 64, idle cycles tolerated inside a grant before forced release.
REQ-003 Parameter CNTW, default 8, width of the beat counter.
REQ-004 i_clk  input  1  clock; all state updates on rising edge.
REQ-005 i_rst_n  input  1  asynchronous, active-low reset.
REQ-006 i_chann_req  input  PORTNUM  per-port request level.
REQ-007 i_port_en  input  PORTNUM  per-port enable mask; a masked port is never granted.
REQ-008 i_beat_vld  input  1  one data beat of the granted port transferred this cycle.
REQ-009 i_beat_last  input  1  qualifies i_beat_vld as the final beat of the packet.
REQ-010 o_grant  output  PORTNUM  one-hot grant, held for the whole packet.
REQ-011 o_grant_idx  output  $clog2(PORTNUM)  binary index of the granted port.
REQ-012 o_grant_vld  output  1  high exactly when o_grant is non-zero.
REQ-013 o_beat_cnt  output  CNTW  beats counted in the current grant.
REQ-014 o_timeout  output  1  one-cycle pulse on forced release.
REQ-015 o_ready  output  1  high in IDLE only.

Function
REQ-016 FSM states: IDLE, GRANT, RELEASE.
REQ-017 Eligible set = i_chann_req & i_port_en.
REQ-018 IDLE with non-empty eligible set at edge N: GRANT from N+1, with o_grant, o_grant_idx and o_grant_vld registered at that edge.
REQ-019 Winner = first eligible port at or above (last_winner+1) mod PORTNUM, searching upward with wrap-around.
REQ-020 last_winner resets to PORTNUM-1, so port 0 has first priority after reset.
REQ-021 last_winner updates to the granted index on entry to GRANT.
REQ-022 In GRANT, each i_beat_vld increments o_beat_cnt; o_beat_cnt saturates at 2^CNTW-1 and does not wrap.
REQ-023 In GRANT, i_beat_vld && i_beat_last at edge M: next state RELEASE; o_grant, o_grant_vld clear at M+1.
REQ-024 In GRANT, the idle counter increments each cycle without i_beat_vld and clears on any beat.
REQ-025 Idle counter reaching TIMEOUT-1 without a beat: RELEASE next cycle, o_timeout pulses for that single cycle, grant clears.
REQ-026 A beat in the same cycle as the timeout threshold wins: no timeout; REQ-023 applies if i_beat_last is set.
REQ-027 Requests withdrawn or masked during GRANT are ignored; the grant holds until last beat or timeout.
REQ-028 i_beat_vld outside GRANT is ignored.
REQ-029 RELEASE lasts exactly one cycle with all grant outputs zero, then IDLE; minimum grant-to-grant gap is 2 idle cycles.
REQ-030 o_beat_cnt and the idle counter clear on entry to GRANT; o_beat_cnt holds its final value through RELEASE and IDLE.
REQ-031 o_ready = (state == IDLE).

Reset
REQ-032 Asynchronous assertion forces state IDLE, o_grant=0, o_grant_idx=0, o_grant_vld=0, o_beat_cnt=0, o_timeout=0, o_ready=1, last_winner=PORTNUM-1, idle counter 0.
REQ-033 Reset mid-grant drops the grant immediately; no o_timeout pulse.
REQ-034 Arbitration resumes on the first clock edge after deassertion.

Structure
REQ-035 Package chan_sched_pkg holds the FSM state enum and the default PORTNUM and TIMEOUT constants.
REQ-036 A combinational sub-module rr_pick takes the eligible vector and last_winner and returns the one-hot winner, winner index and valid; it is instantiated once.

Verification
REQ-037 Reset, then req=0x0005, en=0xFFFF: grant=0x0001 one cycle after request; 3 beats with the last flagged; o_beat_cnt=3; grant clears; next grant=0x0004.
REQ-038 All 16 ports requesting continuously, each packet 1 beat: grant index sequence 0,1,...,15,0 with a 2-cycle gap between grants.
REQ-039 TIMEOUT=64, port 3 granted, no beats: o_timeout pulses exactly once, 64 cycles after grant entry; grant drops that cycle.
REQ-040 req=0x00F0, en=0x00E0: port 4 is never granted; grants rotate over 5,6,7.
REQ-041 Grant to port 2, i_chann_req cleared after 1 beat: grant holds until the beat with i_beat_last set.
REQ-042 i_rst_n pulsed low mid-grant: all outputs at reset values immediately; the next grant goes to the lowest eligible port.
